// File: rtl/core_pkg.sv
// Core-wide configuration shared by the execution-stage units.
//   DATA_WIDTH : architectural operand/result width.
package core_pkg;

    localparam int unsigned DATA_WIDTH = 32;

endpackage

// File: rtl/div_control_pkg.sv
// Divider operation codes, FSM state type and op-class helper.
//   DIV_WIDTH_CODE : width of the div_control op-select field.
//   div_control_t  : DIV / DIVU / REM / REMU encodings.
//   div_state_t    : IDLE -> CALC -> FINISH.
package div_control_pkg;

    localparam int unsigned DIV_WIDTH_CODE = 2;

    typedef enum logic [DIV_WIDTH_CODE-1:0] {
        div_div  = 2'b00,
        div_divu = 2'b01,
        div_rem  = 2'b10,
        div_remu = 2'b11
    } div_control_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CALC   = 2'b01,
        FINISH = 2'b10
    } div_state_t;

    // Signed ops work on magnitudes and need a sign fix at the end.
    function automatic logic is_signed_op(input div_control_t op);
        return (op == div_div) || (op == div_rem);
    endfunction

endpackage

// File: rtl/core_div_step.sv
// One restoring shift-subtract iteration (combinational).
//   rem, quo, divisor   : current partial remainder, dividend/quotient shift
//                         register and divisor magnitude.
//   rem_next, quo_next  : values after shifting in quo's MSB and a
//                         conditional subtract; new quotient bit in quo_next[0].
module core_div_step
    import core_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] rem,
    input  logic [DATA_WIDTH-1:0] quo,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] rem_next,
    output logic [DATA_WIDTH-1:0] quo_next
);

    localparam int unsigned W = DATA_WIDTH;

    // One extra bit keeps the shifted remainder exact for divisors >= 2^(W-1).
    logic [W:0] partial;
    logic       take;

    assign partial = {rem, quo[W-1]};
    assign take    = (partial >= {1'b0, divisor});

    always_comb begin
        if (take) begin
            rem_next = W'(partial - {1'b0, divisor});
            quo_next = {quo[W-2:0], 1'b1};
        end else begin
            rem_next = partial[W-1:0];
            quo_next = {quo[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/core_div.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
//   clk, rst_n   : clock, asynchronous active-low reset
//   div_control  : op select (div_div, div_divu, div_rem, div_remu)
//   div_start    : request, sampled only while div_ready=1
//   div_kill     : flush; aborts any in-flight op, wins over div_start
//   div_in_a/b   : dividend / divisor
//   div_ready    : 1 while idle
//   div_done     : one-cycle strobe, div_out valid in the same cycle
//   div_out      : quotient or remainder, held until the next completion
// Build option: DIV_EARLY_OUT_EN skips the loop for b==0, signed overflow
// and |a|<|b|.
module core_div
    import core_pkg::*;
    import div_control_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DIV_WIDTH_CODE-1:0] div_control,
    input  logic                      div_start,
    input  logic                      div_kill,
    input  logic [DATA_WIDTH-1:0]     div_in_a,
    input  logic [DATA_WIDTH-1:0]     div_in_b,
    output logic                      div_ready,
    output logic                      div_done,
    output logic [DATA_WIDTH-1:0]     div_out
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    div_state_t     state, next_state;
    div_control_t   op_q, op_d;
    logic           sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic           b_zero_q, b_zero_d, ovf_q, ovf_d;
    logic [W-1:0]   a_raw_q, a_raw_d, divisor_q, divisor_d;
    logic [W-1:0]   quo_q, quo_d, rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]   out_d;
    logic           done_d, ready_d;

    // Request decode, only meaningful in IDLE.
    div_control_t   op_in;
    logic           signed_in, sign_a_in, sign_b_in, b_zero_in, ovf_in;
    logic           early_in, accept;
    logic [W-1:0]   mag_a_in, mag_b_in;

    always_comb begin
        op_in     = div_control_t'(div_control);
        signed_in = is_signed_op(op_in);
        sign_a_in = signed_in & div_in_a[W-1];
        sign_b_in = signed_in & div_in_b[W-1];
        mag_a_in  = sign_a_in ? W'(-div_in_a) : div_in_a;
        mag_b_in  = sign_b_in ? W'(-div_in_b) : div_in_b;
        b_zero_in = (div_in_b == '0);
        ovf_in    = signed_in && (div_in_a == MIN_NEG) && (div_in_b == '1);
        accept    = div_start & ~div_kill;
`ifdef DIV_EARLY_OUT_EN
        early_in  = b_zero_in | ovf_in | (mag_a_in < mag_b_in);
`else
        early_in  = 1'b0;
`endif
    end

    logic [W-1:0] step_rem, step_quo;

    core_div_step u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (divisor_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    // Sign fix plus ISA-mandated special cases, selected by op.
    logic [W-1:0] quo_fix, rem_fix, result;

    always_comb begin
        quo_fix = (sign_a_q ^ sign_b_q) ? W'(-quo_q) : quo_q;
        rem_fix = sign_a_q ? W'(-rem_q) : rem_q;
        if (b_zero_q) begin
            quo_fix = '1;
            rem_fix = a_raw_q;
        end else if (ovf_q) begin
            quo_fix = MIN_NEG;
            rem_fix = '0;
        end
        case (op_q)
            div_rem, div_remu: result = rem_fix;
            default:           result = quo_fix;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) next_state = early_in ? FINISH : CALC;
            end
            CALC: begin
                if (div_kill)                  next_state = IDLE;
                else if (cnt_q == CNT_W'(1))   next_state = FINISH;
            end
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        op_d      = op_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        b_zero_d  = b_zero_q;
        ovf_d     = ovf_q;
        a_raw_d   = a_raw_q;
        divisor_d = divisor_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        out_d     = div_out;
        done_d    = 1'b0;
        ready_d   = (next_state == IDLE);
        case (state)
            IDLE: begin
                if (accept) begin
                    op_d      = op_in;
                    sign_a_d  = sign_a_in;
                    sign_b_d  = sign_b_in;
                    b_zero_d  = b_zero_in;
                    ovf_d     = ovf_in;
                    a_raw_d   = div_in_a;
                    divisor_d = mag_b_in;
                    cnt_d     = CNT_W'(W);
                    // Early exit preloads the final |a|<|b| answer: q=0, r=|a|.
                    quo_d     = early_in ? '0 : mag_a_in;
                    rem_d     = early_in ? mag_a_in : '0;
                end
            end
            CALC: begin
                if (!div_kill) begin
                    quo_d = step_quo;
                    rem_d = step_rem;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FINISH: begin
                if (!div_kill) begin
                    out_d  = result;
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= div_div;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            b_zero_q  <= 1'b0;
            ovf_q     <= 1'b0;
            a_raw_q   <= '0;
            divisor_q <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            div_out   <= '0;
            div_done  <= 1'b0;
            div_ready <= 1'b1;
        end else begin
            op_q      <= op_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            b_zero_q  <= b_zero_d;
            ovf_q     <= ovf_d;
            a_raw_q   <= a_raw_d;
            divisor_q <= divisor_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            div_out   <= out_d;
            div_done  <= done_d;
            div_ready <= ready_d;
        end
    end

endmodule
